// File: rtl/avalon_st_pkt_fifo.sv
// Avalon-ST packet FIFO: cut-through (STORE_FWD=0) or store-and-forward (STORE_FWD=1).
// Optional framing checker with sticky err output when AVST_PKT_FIFO_ERR_CHECK_EN is defined.
module avalon_st_pkt_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int STORE_FWD  = 0,
  localparam int EW = $clog2(DATA_WIDTH),
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic                  in_sop,
  input  logic                  in_eop,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [EW-1:0]         in_empty,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [EW-1:0]         out_empty,
  output logic [CW-1:0]         fill_level,
  output logic [CW-1:0]         pkt_count
`ifdef AVST_PKT_FIFO_ERR_CHECK_EN
  ,
  output logic                  err
`endif
);

  logic [DATA_WIDTH-1:0] r_data_mem  [DEPTH];
  logic [EW-1:0]         r_empty_mem [DEPTH];
  logic [DEPTH-1:0]      r_sop_mem;
  logic [DEPTH-1:0]      r_eop_mem;
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_fill;
  logic [CW-1:0]         r_pkts;

  logic w_push;
  logic w_pop;
  logic w_push_eop;
  logic w_pop_eop;
  logic w_nonempty;

  // Ready derives from stored occupancy only, so a same-cycle pop never frees a slot early.
  assign in_rdy     = ~rst & (r_fill < CW'(DEPTH));
  assign w_nonempty = (r_fill != '0);
  assign out_vld    = (STORE_FWD != 0) ? (w_nonempty & (r_pkts != '0)) : w_nonempty;

  assign w_push     = in_vld & in_rdy;
  assign w_pop      = out_vld & out_rdy;
  assign w_push_eop = w_push & in_eop;
  assign w_pop_eop  = w_pop & r_eop_mem[r_rd_ptr];

  assign out_sop    = r_sop_mem[r_rd_ptr];
  assign out_eop    = r_eop_mem[r_rd_ptr];
  assign out_data   = r_data_mem[r_rd_ptr];
  assign out_empty  = r_empty_mem[r_rd_ptr];
  assign fill_level = r_fill;
  assign pkt_count  = r_pkts;

  // Storage: beat contents carry no reset; pointers qualify their validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_data_mem[r_wr_ptr]  <= in_data;
      r_empty_mem[r_wr_ptr] <= in_empty;
      r_sop_mem[r_wr_ptr]   <= in_sop;
      r_eop_mem[r_wr_ptr]   <= in_eop;
    end
  end

  // Control: pointers, occupancy and complete-packet count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
      r_pkts   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + CW'(1);
        2'b01:   r_fill <= r_fill - CW'(1);
        default: r_fill <= r_fill;
      endcase
      r_pkts <= r_pkts + CW'(w_push_eop) - CW'(w_pop_eop);
    end
  end

`ifdef AVST_PKT_FIFO_ERR_CHECK_EN
  logic r_in_pkt;
  logic r_err;
  logic w_frame_err;
  logic w_oversize;

  assign w_frame_err = w_push & ((in_sop & r_in_pkt) |
                                 (~in_sop & ~r_in_pkt) |
                                 ((in_empty != '0) & ~in_eop));
  // Full of beats with no eop stored can never drain in store-and-forward mode.
  assign w_oversize  = (STORE_FWD != 0) & (r_fill == CW'(DEPTH)) & (r_pkts == '0);
  assign err         = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_pkt <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_push) begin
        r_in_pkt <= ~in_eop;
      end
      if (w_frame_err | w_oversize) begin
        r_err <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_avalon_st_pkt_fifo.sv
// Bench for avalon_st_pkt_fifo: one cut-through and one store-and-forward instance,
// directed scenarios plus randomized traffic against a queue-style reference model.
module tb_avalon_st_pkt_fifo;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int EW    = $clog2(DW);
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int NPKT  = 1000;
  localparam int MAXB  = 16384;

  logic clk = 1'b0;
  logic rst;
  logic [1:0]    in_vld, in_sop, in_eop, out_rdy;
  logic [DW-1:0] in_data  [2];
  logic [EW-1:0] in_empty [2];
  logic [1:0]    in_rdy, out_vld, out_sop, out_eop;
  logic [DW-1:0] out_data  [2];
  logic [EW-1:0] out_empty [2];
  logic [CW-1:0] fill [2];
  logic [CW-1:0] pkts [2];
`ifdef AVST_PKT_FIFO_ERR_CHECK_EN
  logic [1:0]    err;
`endif

  always #5 clk = ~clk;

  avalon_st_pkt_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .STORE_FWD(0)) u_ct (
    .clk(clk), .rst(rst),
    .in_vld(in_vld[0]), .in_rdy(in_rdy[0]), .in_sop(in_sop[0]), .in_eop(in_eop[0]),
    .in_data(in_data[0]), .in_empty(in_empty[0]),
    .out_vld(out_vld[0]), .out_rdy(out_rdy[0]), .out_sop(out_sop[0]), .out_eop(out_eop[0]),
    .out_data(out_data[0]), .out_empty(out_empty[0]),
    .fill_level(fill[0]), .pkt_count(pkts[0])
`ifdef AVST_PKT_FIFO_ERR_CHECK_EN
    , .err(err[0])
`endif
  );

  avalon_st_pkt_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .STORE_FWD(1)) u_sf (
    .clk(clk), .rst(rst),
    .in_vld(in_vld[1]), .in_rdy(in_rdy[1]), .in_sop(in_sop[1]), .in_eop(in_eop[1]),
    .in_data(in_data[1]), .in_empty(in_empty[1]),
    .out_vld(out_vld[1]), .out_rdy(out_rdy[1]), .out_sop(out_sop[1]), .out_eop(out_eop[1]),
    .out_data(out_data[1]), .out_empty(out_empty[1]),
    .fill_level(fill[1]), .pkt_count(pkts[1])
`ifdef AVST_PKT_FIFO_ERR_CHECK_EN
    , .err(err[1])
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [DW-1:0] data;
    logic [EW-1:0] empty;
  } beat_t;

  // Reference model: every accepted beat in order, plus push/pop and eop counters.
  beat_t exp_q [2][MAXB];
  int np [2];
  int nq [2];
  int ep [2];
  int eq [2];

  function automatic logic m_vld(int i);
    return ((np[i] - nq[i]) != 0) && (i == 0 || (ep[i] - eq[i]) != 0);
  endfunction

  task automatic idle_inputs();
    for (int i = 0; i < 2; i++) begin
      in_vld[i] = 1'b0; in_sop[i] = 1'b0; in_eop[i] = 1'b0;
      in_data[i] = '0; in_empty[i] = '0; out_rdy[i] = 1'b0;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if (in_rdy[i] !== 1'b0) begin
        n_fail++; $display("FAIL rst_in_rdy[%0d]: got %b want 0", i, in_rdy[i]);
      end
      n_chk++;
      if (out_vld[i] !== 1'b0) begin
        n_fail++; $display("FAIL rst_out_vld[%0d]: got %b want 0", i, out_vld[i]);
      end
      n_chk++;
      if (fill[i] !== '0 || pkts[i] !== '0) begin
        n_fail++; $display("FAIL rst_counts[%0d]: fill %0d pkts %0d want 0 0", i, fill[i], pkts[i]);
      end
`ifdef AVST_PKT_FIFO_ERR_CHECK_EN
      n_chk++;
      if (err[i] !== 1'b0) begin
        n_fail++; $display("FAIL rst_err[%0d]: got %b want 0", i, err[i]);
      end
`endif
    end
    rst = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if (in_rdy[i] !== 1'b1) begin
        n_fail++; $display("FAIL post_rst_in_rdy[%0d]: got %b want 1", i, in_rdy[i]);
      end
    end
  endtask

  task automatic test_single_beat();
    for (int i = 0; i < 2; i++) begin
      test_reset();
      out_rdy[i] = 1'b0;
      in_vld[i] = 1'b1; in_sop[i] = 1'b1; in_eop[i] = 1'b1;
      in_data[i] = 32'hA5A5A5A5; in_empty[i] = EW'(3);
      #1;
      n_chk++;
      if (out_vld[i] !== 1'b0) begin
        n_fail++; $display("FAIL single_no_comb_path[%0d]: out_vld %b want 0", i, out_vld[i]);
      end
      @(posedge clk); @(negedge clk);
      in_vld[i] = 1'b0;
      n_chk++;
      if (out_vld[i] !== 1'b1 || out_data[i] !== 32'hA5A5A5A5 || out_sop[i] !== 1'b1 ||
          out_eop[i] !== 1'b1 || out_empty[i] !== EW'(3)) begin
        n_fail++;
        $display("FAIL single_beat[%0d]: vld %b data %h sop %b eop %b empty %0d want 1 a5a5a5a5 1 1 3",
                 i, out_vld[i], out_data[i], out_sop[i], out_eop[i], out_empty[i]);
      end
      n_chk++;
      if (fill[i] !== CW'(1) || pkts[i] !== CW'(1)) begin
        n_fail++; $display("FAIL single_counts[%0d]: fill %0d pkts %0d want 1 1", i, fill[i], pkts[i]);
      end
      out_rdy[i] = 1'b1;
      @(posedge clk); @(negedge clk);
      out_rdy[i] = 1'b0;
      n_chk++;
      if (out_vld[i] !== 1'b0 || fill[i] !== '0 || pkts[i] !== '0) begin
        n_fail++;
        $display("FAIL single_drain[%0d]: vld %b fill %0d pkts %0d want 0 0 0", i, out_vld[i], fill[i], pkts[i]);
      end
    end
  endtask

  task automatic test_fill_full();
    test_reset();
    out_rdy[0] = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      in_vld[0] = 1'b1; in_sop[0] = (k == 0); in_eop[0] = 1'b0;
      in_data[0] = DW'(k); in_empty[0] = '0;
      n_chk++;
      if (in_rdy[0] !== 1'b1) begin
        n_fail++; $display("FAIL fill_rdy_k%0d: in_rdy %b want 1", k, in_rdy[0]);
      end
      @(posedge clk); @(negedge clk);
    end
    in_data[0] = DW'(DEPTH);
    in_sop[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_chk++;
      if (in_rdy[0] !== 1'b0 || fill[0] !== CW'(DEPTH) || out_data[0] !== '0) begin
        n_fail++;
        $display("FAIL full_hold_c%0d: in_rdy %b fill %0d head %0d want 0 16 0", c, in_rdy[0], fill[0], out_data[0]);
      end
      @(posedge clk); @(negedge clk);
    end
    out_rdy[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    n_chk++;
    if (fill[0] !== CW'(DEPTH - 1) || in_rdy[0] !== 1'b1 || out_data[0] !== DW'(1)) begin
      n_fail++;
      $display("FAIL full_push_pop: fill %0d in_rdy %b head %0d want 15 1 1", fill[0], in_rdy[0], out_data[0]);
    end
    out_rdy[0] = 1'b0;
    @(posedge clk); @(negedge clk);
    in_vld[0] = 1'b0;
    n_chk++;
    if (fill[0] !== CW'(DEPTH) || pkts[0] !== '0) begin
      n_fail++; $display("FAIL full_17th: fill %0d pkts %0d want 16 0", fill[0], pkts[0]);
    end
    out_rdy[0] = 1'b1;
    for (int k = 1; k <= DEPTH; k++) begin
      n_chk++;
      if (out_vld[0] !== 1'b1 || out_data[0] !== DW'(k)) begin
        n_fail++; $display("FAIL full_drain_k%0d: vld %b data %0d want 1 %0d", k, out_vld[0], out_data[0], k);
      end
      @(posedge clk); @(negedge clk);
    end
    out_rdy[0] = 1'b0;
    n_chk++;
    if (out_vld[0] !== 1'b0 || fill[0] !== '0) begin
      n_fail++; $display("FAIL full_empty: vld %b fill %0d want 0 0", out_vld[0], fill[0]);
    end
  endtask

  task automatic test_store_fwd();
    test_reset();
    out_rdy[1] = 1'b1;
    for (int b = 0; b < 4; b++) begin
      in_vld[1] = 1'b1; in_sop[1] = (b == 0); in_eop[1] = (b == 3);
      in_data[1] = 32'h100 + DW'(b); in_empty[1] = (b == 3) ? EW'(2) : EW'(0);
      @(posedge clk); @(negedge clk);
      in_vld[1] = 1'b0;
      if (b < 3) begin
        for (int g = 0; g < 3; g++) begin
          n_chk++;
          if (out_vld[1] !== 1'b0) begin
            n_fail++; $display("FAIL sf_hold_b%0d_g%0d: out_vld %b want 0", b, g, out_vld[1]);
          end
          if (g < 2) begin
            @(posedge clk); @(negedge clk);
          end
        end
      end
    end
    n_chk++;
    if (out_vld[1] !== 1'b1 || pkts[1] !== CW'(1) || fill[1] !== CW'(4)) begin
      n_fail++;
      $display("FAIL sf_release: vld %b pkts %0d fill %0d want 1 1 4", out_vld[1], pkts[1], fill[1]);
    end
    for (int b = 0; b < 4; b++) begin
      n_chk++;
      if (out_vld[1] !== 1'b1 || out_data[1] !== 32'h100 + DW'(b) || out_sop[1] !== (b == 0) ||
          out_eop[1] !== (b == 3)) begin
        n_fail++;
        $display("FAIL sf_beat_b%0d: vld %b data %h sop %b eop %b want 1 %h %b %b", b, out_vld[1],
                 out_data[1], out_sop[1], out_eop[1], 32'h100 + b, b == 0, b == 3);
      end
      @(posedge clk); @(negedge clk);
    end
    out_rdy[1] = 1'b0;
    n_chk++;
    if (out_vld[1] !== 1'b0 || pkts[1] !== '0) begin
      n_fail++; $display("FAIL sf_done: vld %b pkts %0d want 0 0", out_vld[1], pkts[1]);
    end
  endtask

  task automatic test_random();
    int plen [2];
    int bidx [2];
    int sent [2];
    logic push_r [2];
    logic pop_r [2];
    int cyc;
    logic done;
    beat_t e;
    test_reset();
    for (int i = 0; i < 2; i++) begin
      np[i] = 0; nq[i] = 0; ep[i] = 0; eq[i] = 0;
      plen[i] = 1; bidx[i] = 0; sent[i] = 0; push_r[i] = 1'b0; pop_r[i] = 1'b0;
    end
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < 60000 && n_fail < 50) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (pop_r[i]) begin
          if (exp_q[i][nq[i]].eop) eq[i]++;
          nq[i]++;
        end
        if (push_r[i]) begin
          e.sop = in_sop[i]; e.eop = in_eop[i]; e.data = in_data[i]; e.empty = in_empty[i];
          exp_q[i][np[i]] = e;
          np[i]++;
          if (in_eop[i]) begin
            ep[i]++; sent[i]++; bidx[i] = 0;
          end else begin
            bidx[i]++;
          end
          in_vld[i] = 1'b0;
        end
        n_chk++;
        if (fill[i] !== CW'(np[i] - nq[i]) || pkts[i] !== CW'(ep[i] - eq[i])) begin
          n_fail++;
          $display("FAIL rnd_counts[%0d] cyc %0d: fill %0d pkts %0d want %0d %0d", i, cyc,
                   fill[i], pkts[i], np[i] - nq[i], ep[i] - eq[i]);
        end
        n_chk++;
        if (in_rdy[i] !== ((np[i] - nq[i]) < DEPTH) || out_vld[i] !== m_vld(i)) begin
          n_fail++;
          $display("FAIL rnd_hs[%0d] cyc %0d: in_rdy %b out_vld %b want %b %b", i, cyc,
                   in_rdy[i], out_vld[i], (np[i] - nq[i]) < DEPTH, m_vld(i));
        end
        if (m_vld(i)) begin
          e = exp_q[i][nq[i]];
          n_chk++;
          if (out_data[i] !== e.data || out_sop[i] !== e.sop || out_eop[i] !== e.eop ||
              out_empty[i] !== e.empty) begin
            n_fail++;
            $display("FAIL rnd_beat[%0d] #%0d: got %h/%b/%b/%0d want %h/%b/%b/%0d", i, nq[i],
                     out_data[i], out_sop[i], out_eop[i], out_empty[i], e.data, e.sop, e.eop, e.empty);
          end
        end
        if (!in_vld[i] && sent[i] < NPKT && $urandom_range(3) != 0) begin
          if (bidx[i] == 0) plen[i] = int'($urandom_range(DEPTH, 1));
          in_vld[i] = 1'b1;
          in_sop[i] = (bidx[i] == 0);
          in_eop[i] = (bidx[i] == plen[i] - 1);
          in_data[i] = $urandom;
          in_empty[i] = in_eop[i] ? EW'($urandom_range(DW - 1)) : EW'(0);
        end
        out_rdy[i] = ($urandom_range(3) != 0);
        push_r[i] = in_vld[i] && ((np[i] - nq[i]) < DEPTH);
        pop_r[i] = out_rdy[i] && m_vld(i);
      end
      done = (sent[0] == NPKT) && (sent[1] == NPKT) && (np[0] == nq[0]) && (np[1] == nq[1]) &&
             !in_vld[0] && !in_vld[1];
    end
    @(posedge clk); @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if (sent[i] != NPKT || np[i] != nq[i] || fill[i] !== '0) begin
        n_fail++;
        $display("FAIL rnd_complete[%0d]: pkts %0d pushed %0d popped %0d fill %0d want %0d all drained",
                 i, sent[i], np[i], nq[i], fill[i], NPKT);
      end
`ifdef AVST_PKT_FIFO_ERR_CHECK_EN
      n_chk++;
      if (err[i] !== 1'b0) begin
        n_fail++; $display("FAIL rnd_err[%0d]: got %b want 0", i, err[i]);
      end
`endif
    end
    idle_inputs();
  endtask

`ifdef AVST_PKT_FIFO_ERR_CHECK_EN
  task automatic test_err();
    test_reset();
    in_vld[0] = 1'b1; in_sop[0] = 1'b1; in_eop[0] = 1'b0; in_data[0] = 32'h1;
    @(posedge clk); @(negedge clk);
    n_chk++;
    if (err[0] !== 1'b0) begin
      n_fail++; $display("FAIL err_first_sop: got %b want 0", err[0]);
    end
    in_data[0] = 32'h2;
    @(posedge clk); @(negedge clk);
    in_vld[0] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      n_chk++;
      if (err[0] !== 1'b1) begin
        n_fail++; $display("FAIL err_sticky_c%0d: got %b want 1", c, err[0]);
      end
      @(posedge clk); @(negedge clk);
    end
    n_chk++;
    if (fill[0] !== CW'(2)) begin
      n_fail++; $display("FAIL err_stored: fill %0d want 2", fill[0]);
    end
    test_reset();
    in_vld[0] = 1'b1; in_sop[0] = 1'b1; in_eop[0] = 1'b0; in_empty[0] = EW'(1);
    @(posedge clk); @(negedge clk);
    in_vld[0] = 1'b0;
    n_chk++;
    if (err[0] !== 1'b1) begin
      n_fail++; $display("FAIL err_empty_no_eop: got %b want 1", err[0]);
    end
    test_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_single_beat();
    test_fill_full();
    test_store_fwd();
    test_random();
`ifdef AVST_PKT_FIFO_ERR_CHECK_EN
    test_err();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
